// File: rtl/cdc_bus_arbiter_pkg.sv
// Shared definitions for the source-domain CDC bus arbiter: FSM state
// encodings, a constant-foldable clog2 and the id-width consistency check.
package cdc_arb_pkg;

    // FSM state encodings, kept as plain constants for legacy tool flows.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t StIdle  = 2'd0;
    localparam arb_state_t StIssue = 2'd1;
    localparam arb_state_t StHold  = 2'd2;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    // The id tag must be exactly wide enough to name every requester.
    function automatic logic id_width_ok(input int unsigned num_req,
                                         input int unsigned id_width);
        return id_width == clog2(num_req);
    endfunction

endpackage

// File: rtl/cdc_bus_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts just above last_grant
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any_req
);

    logic found;

    // Two passes: indices above last_grant first, then wrap to the lowest index.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        any_req   = |req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > int'(last_grant))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/cdc_bus_arbiter.sv
// Source-domain scheduler sharing one pulse-based CDC channel between several
// requesters. Each accepted word is tagged with its requester id and the
// transfer pulses are spaced at least HOLDOFF clocks apart so the destination
// toggle synchronizer never misses or merges a request.
module cdc_bus_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned HOLDOFF    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           cdc_req,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] cdc_din,
    output logic                           busy
);

    import cdc_arb_pkg::*;

    localparam int unsigned          HoldWidth    = clog2(HOLDOFF);
    localparam logic [HoldWidth-1:0] HoldLoad     = HoldWidth'(HOLDOFF - 2);
    localparam logic [ID_WIDTH-1:0]  LastGrantRst = ID_WIDTH'(NUM_REQ - 1);

    if (!id_width_ok(NUM_REQ, ID_WIDTH)) begin : g_bad_id_width
        $error("cdc_bus_arbiter: ID_WIDTH must equal clog2(NUM_REQ)");
    end
    if (HOLDOFF < 2) begin : g_bad_holdoff
        $error("cdc_bus_arbiter: HOLDOFF must be at least 2");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("cdc_bus_arbiter: NUM_REQ must be in 2..16");
    end

    arb_state_t                     state_q, state_d;
    logic [HoldWidth-1:0]           hold_cnt_q, hold_cnt_d;
    logic [ID_WIDTH-1:0]            last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]             req_ready_d;
    logic                           cdc_req_d;
    logic [ID_WIDTH+DATA_WIDTH-1:0] cdc_din_d;

    logic [NUM_REQ-1:0]             grant;
    logic [ID_WIDTH-1:0]            grant_idx;
    logic                           any_req;
    logic [DATA_WIDTH-1:0]          grant_data;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_req    (any_req)
    );

    // Select the winner's payload from the packed request bus.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, pulse for one cycle, then hold off.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_grant_d = last_grant_q;
        req_ready_d  = '0;
        cdc_req_d    = 1'b0;
        cdc_din_d    = cdc_din;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d      = StIssue;
                    last_grant_d = grant_idx;
                    req_ready_d  = grant;
                    cdc_req_d    = 1'b1;
                    cdc_din_d    = {grant_idx, grant_data};
                end
            end
            StIssue: begin
                // With HOLDOFF == 2 the IDLE arbitration cycle alone gives the gap.
                if (HOLDOFF > 2) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                hold_cnt_d = hold_cnt_q - 1'b1;
                if (hold_cnt_q == HoldWidth'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset clears the outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            last_grant_q <= LastGrantRst;
            req_ready    <= '0;
            cdc_req      <= 1'b0;
            cdc_din      <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
            req_ready    <= req_ready_d;
            cdc_req      <= cdc_req_d;
            cdc_din      <= cdc_din_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule
